button_debounce_array: RTL and testbench

//  Multi-channel push-button/switch conditioner for the Spartan3E board I/O path.

---
 rtl/button_debounce_array_pkg.sv | 41 ++++
 rtl/button_debounce_array_channel.sv | 145 ++++++++++++++
 rtl/button_debounce_array.sv | 68 ++++++
 tb/tb_button_debounce_array.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/button_debounce_array_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce_array_pkg
//  Description : Shared types and helpers for the button debounce array.
//                Holds the repeat-FSM state encoding and the width helpers
//                used to size the prescaler and per-channel counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package button_debounce_array_pkg;

    // Auto-repeat FSM states; the encoding is fixed so state values stay
    // stable across revisions.
    typedef enum logic [1:0] {
        ST_RELEASED  = 2'd0,
        ST_HOLD_WAIT = 2'd1,
        ST_REPEATING = 2'd2
    } rep_state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Bits needed to hold 0..max_val, never less than one bit.
    function automatic int width_for(input int max_val);
        int w;
        w = clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : button_debounce_array_pkg
`default_nettype wire

// File: rtl/button_debounce_array_channel.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce_array_channel
//  Description : One input channel: synchroniser, tick-gated debounce
//                counter, registered level/press/release and the
//                auto-repeat FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debounce_array_channel
    import button_debounce_array_pkg::*;
#(
    parameter int STABLE_COUNT = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic tick_i,
    input  logic raw_i,
    input  logic repeat_en_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam int DCNT_W = width_for(STABLE_COUNT);
    localparam int RCNT_W = width_for(max2(REPEAT_DELAY, REPEAT_RATE));

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_w;
    logic [DCNT_W-1:0]      dcnt_q;
    logic [DCNT_W-1:0]      dcnt_d;
    logic                   level_q;
    logic                   level_d;
    logic                   press_q;
    logic                   release_q;
    logic                   repeat_q;
    logic [RCNT_W-1:0]      rcnt_q;
    logic [RCNT_W-1:0]      rcnt_inc_w;
    rep_state_e             state_q;

    // Only the last synchroniser stage is ever observed.
    assign sync_w     = sync_q[SYNC_STAGES-1];
    assign rcnt_inc_w = rcnt_q + RCNT_W'(1);

    // Shift the raw input through the synchroniser chain.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    // Next debounce count and level; any agreeing tick clears the run.
    always_comb begin
        dcnt_d  = dcnt_q;
        level_d = level_q;
        if (tick_i) begin
            if (sync_w == level_q) begin
                dcnt_d = '0;
            end else if (dcnt_q == DCNT_W'(STABLE_COUNT - 1)) begin
                level_d = ~level_q;
                dcnt_d  = '0;
            end else begin
                dcnt_d = dcnt_q + DCNT_W'(1);
            end
        end
    end

    // Register level and the edge pulses that coincide with a level change.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            dcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            dcnt_q    <= dcnt_d;
            level_q   <= level_d;
            press_q   <= level_d & ~level_q;
            release_q <= ~level_d & level_q;
        end
    end

    // Auto-repeat FSM; follows the next level so it leaves RELEASED on the
    // press cycle and release always beats a coincident repeat.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= ST_RELEASED;
            rcnt_q   <= '0;
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= 1'b0;
            if (!level_d) begin
                state_q <= ST_RELEASED;
                rcnt_q  <= '0;
            end else if (!repeat_en_i) begin
                state_q <= ST_HOLD_WAIT;
                rcnt_q  <= '0;
            end else begin
                case (state_q)
                    ST_RELEASED: begin
                        state_q <= ST_HOLD_WAIT;
                        rcnt_q  <= '0;
                    end
                    ST_HOLD_WAIT: begin
                        if (tick_i) begin
                            if (rcnt_inc_w == RCNT_W'(REPEAT_DELAY)) begin
                                repeat_q <= 1'b1;
                                rcnt_q   <= '0;
                                state_q  <= ST_REPEATING;
                            end else begin
                                rcnt_q <= rcnt_inc_w;
                            end
                        end
                    end
                    ST_REPEATING: begin
                        if (tick_i) begin
                            if (rcnt_inc_w == RCNT_W'(REPEAT_RATE)) begin
                                repeat_q <= 1'b1;
                                rcnt_q   <= '0;
                            end else begin
                                rcnt_q <= rcnt_inc_w;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_RELEASED;
                        rcnt_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign repeat_o  = repeat_q;

endmodule : button_debounce_array_channel
`default_nettype wire

// File: rtl/button_debounce_array.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce_array
//  Description : Multi-channel push-button conditioner. A shared prescaler
//                produces the sample tick; each channel is synchronised,
//                debounced and given press/release/auto-repeat pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debounce_array
    import button_debounce_array_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_COUNT = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic [CHANNELS-1:0] raw_in_i,
    input  logic [CHANNELS-1:0] repeat_en_i,
    output logic [CHANNELS-1:0] level_o,
    output logic [CHANNELS-1:0] press_o,
    output logic [CHANNELS-1:0] release_o,
    output logic [CHANNELS-1:0] repeat_o
);

    localparam int PRE_W = width_for(TICK_DIV - 1);

    logic [PRE_W-1:0] presc_q;
    logic             tick_w;

    // Tick fires on the terminal count; TICK_DIV=1 makes it permanent.
    assign tick_w = (presc_q == PRE_W'(TICK_DIV - 1));

    // Free-running prescaler shared by every channel.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            presc_q <= '0;
        end else if (tick_w) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PRE_W'(1);
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_channel
        button_debounce_array_channel #(
            .STABLE_COUNT (STABLE_COUNT),
            .SYNC_STAGES  (SYNC_STAGES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_channel (
            .clock_i     (clock_i),
            .reset_i     (reset_i),
            .tick_i      (tick_w),
            .raw_i       (raw_in_i[g]),
            .repeat_en_i (repeat_en_i[g]),
            .level_o     (level_o[g]),
            .press_o     (press_o[g]),
            .release_o   (release_o[g]),
            .repeat_o    (repeat_o[g])
        );
    end

endmodule : button_debounce_array
`default_nettype wire

// File: tb/tb_button_debounce_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_debounce_array
//  Description : Directed self-checking bench for button_debounce_array with
//                TICK_DIV=4, STABLE_COUNT=3, SYNC_STAGES=2, REPEAT_DELAY=5,
//                REPEAT_RATE=2 and four channels.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debounce_array;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] raw = 4'h0;
    logic [3:0] ren = 4'h0;
    logic [3:0] level_w;
    logic [3:0] press_w;
    logic [3:0] release_w;
    logic [3:0] repeat_w;

    int n_total = 0;
    int n_bad   = 0;
    int cyc_n   = 0;
    int press_cnt [4] = '{0, 0, 0, 0};
    int rel_cnt   [4] = '{0, 0, 0, 0};
    int rep_cnt   [4] = '{0, 0, 0, 0};

    button_debounce_array #(
        .CHANNELS     (4),
        .TICK_DIV     (4),
        .STABLE_COUNT (3),
        .SYNC_STAGES  (2),
        .REPEAT_DELAY (5),
        .REPEAT_RATE  (2)
    ) dut (
        .clock_i     (clk),
        .reset_i     (rst),
        .raw_in_i    (raw),
        .repeat_en_i (ren),
        .level_o     (level_w),
        .press_o     (press_w),
        .release_o   (release_w),
        .repeat_o    (repeat_w)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (press_w[i])   press_cnt[i] <= press_cnt[i] + 1;
            if (release_w[i]) rel_cnt[i]   <= rel_cnt[i] + 1;
            if (repeat_w[i])  rep_cnt[i]   <= rep_cnt[i] + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p_base;
        int r_base;
        int lat;
        int t_rep [4];
        int nrep;
        int start;
        logic [3:0] acc_p;
        logic [3:0] acc_r;

        // ---- 1: reset with all inputs pressed ----
        rst = 1'b1; raw = 4'hF; ren = 4'h0;
        step(3);
        check_val("t1_rst_level", level_w, 0);
        check_val("t1_rst_press", press_w, 0);
        check_val("t1_rst_release", release_w, 0);
        check_val("t1_rst_repeat", repeat_w, 0);
        rst = 1'b0;
        start = cyc_n;
        for (int k = 0; k < 14 && level_w != 4'hF; k++) step(1);
        check_val("t1_level", level_w, 4'hF);
        check_val("t1_press", press_w, 4'hF);
        check_val("t1_latency", cyc_n - start, 12);
        step(1);
        check_val("t1_press_one_cycle", press_w, 0);
        raw = 4'h0;
        step(20);
        check_val("t1_all_released", level_w, 0);

        // ---- 2: bounce on ch0 then steady press ----
        p_base = press_cnt[0];
        r_base = rel_cnt[0];
        for (int b = 0; b < 4; b++) begin
            raw[0] = (b % 2 == 0);
            step(3);
        end
        check_val("t2_no_press_bounce", press_cnt[0] - p_base, 0);
        raw[0] = 1'b1;
        lat = 99;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            if (press_w[0]) begin
                lat = k;
                break;
            end
        end
        check_val("t2_press_latency_ok", (lat >= 3 && lat <= 14), 1);
        step(20);
        check_val("t2_press_count", press_cnt[0] - p_base, 1);
        check_val("t2_release_count", rel_cnt[0] - r_base, 0);
        check_val("t2_level", level_w[0], 1);

        // ---- 3: single-cycle glitch on ch1 ----
        p_base = press_cnt[1];
        raw[1] = 1'b1;
        step(1);
        raw[1] = 1'b0;
        step(20);
        check_val("t3_level", level_w[1], 0);
        check_val("t3_no_press", press_cnt[1] - p_base, 0);

        // ---- 4: auto-repeat on ch2 ----
        ren[2] = 1'b1;
        raw[2] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step(1);
            if (press_w[2]) break;
        end
        check_val("t4_press_seen", press_w[2], 1);
        start = cyc_n;
        nrep = 0;
        for (int k = 0; k < 4; k++) t_rep[k] = -1;
        for (int k = 0; k < 40; k++) begin
            step(1);
            if (repeat_w[2]) begin
                if (nrep < 4) t_rep[nrep] = cyc_n - start;
                nrep++;
            end
        end
        check_val("t4_repeat_count", nrep, 3);
        check_val("t4_first_repeat", t_rep[0], 20);
        check_val("t4_second_repeat", t_rep[1], 28);
        check_val("t4_third_repeat", t_rep[2], 36);
        r_base = rel_cnt[2];
        raw[2] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (release_w[2]) break;
        end
        check_val("t4_release_seen", release_w[2], 1);
        check_val("t4_no_repeat_on_release", repeat_w[2], 0);
        p_base = rep_cnt[2];
        step(30);
        check_val("t4_no_repeat_after", rep_cnt[2] - p_base, 0);
        check_val("t4_release_count", rel_cnt[2] - r_base, 1);

        // ---- 5: repeat enable dropped and restored on ch3 ----
        ren[3] = 1'b1;
        raw[3] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step(1);
            if (press_w[3]) break;
        end
        check_val("t5_press_seen", press_w[3], 1);
        p_base = rep_cnt[3];
        step(12);
        ren[3] = 1'b0;
        step(16);
        ren[3] = 1'b1;
        start = cyc_n;
        check_val("t5_no_repeat_while_off", rep_cnt[3] - p_base, 0);
        lat = 99;
        for (int k = 1; k <= 30; k++) begin
            step(1);
            if (repeat_w[3]) begin
                lat = k;
                break;
            end
        end
        check_val("t5_repeat_after_reenable", lat, 20);
        raw[3] = 1'b0;
        raw[0] = 1'b0;
        step(20);
        check_val("t5_levels_released", level_w, 0);

        // ---- 6: reset mid-repeat (ch2) and mid-debounce (ch0) ----
        raw[2] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step(1);
            if (press_w[2]) break;
        end
        for (int k = 0; k < 30; k++) begin
            step(1);
            if (repeat_w[2]) break;
        end
        check_val("t6_ch2_repeating", repeat_w[2], 1);
        raw[0] = 1'b1;
        step(9);
        check_val("t6_ch0_pending", level_w[0], 0);
        rst = 1'b1;
        step(1);
        check_val("t6_rst_level", level_w, 0);
        check_val("t6_rst_press", press_w, 0);
        check_val("t6_rst_release", release_w, 0);
        check_val("t6_rst_repeat", repeat_w, 0);
        rst = 1'b0;
        acc_p = 4'h0;
        acc_r = 4'h0;
        for (int k = 1; k <= 11; k++) begin
            step(1);
            acc_p = acc_p | press_w;
            acc_r = acc_r | release_w | repeat_w;
        end
        check_val("t6_no_early_press", acc_p, 0);
        check_val("t6_no_stray_pulse", acc_r, 0);
        step(1);
        check_val("t6_press", press_w, 4'b0101);
        check_val("t6_level", level_w, 4'b0101);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_button_debounce_array
`default_nettype wire
